sprite_obstacle_lane: RTL and testbench
=======================================

# sprite_obstacle_lane

Parametrised obstacle sprite for one lane of the track. It is the generalised successor to the fixed centre-lane obstacle. Each instance advances its own hole obstacle once per video frame, scales it ×1/×2/×4 by depth, and drifts it sideways by a per-lane slope. It also detects a penguin crush, runs its own respawn and crush-hold timers, and drives a registered pixel output into the compositor alongside the other sprite blocks.

## Interface

Parameters:
- X_CENTER, 640: screen x of the lane centre at y = 0.
- X_DRIFT, 0: signed lateral slope; x offset = (X_DRIFT × y) >>> 6 pixels (−64…63).
- Y_BOTTOM, 592: sprite_y at which a fall ends.
- SCALE2_Y, 300: sprite_y at or above which scale is ×2.
- SCALE4_Y, 450: sprite_y at or above which scale is ×4.
- HIT_Y_MIN, 144: sprite_y at or above which collision is reported.
- CRUSH_Y_LO, 540; CRUSH_Y_HI, 550: exclusive crush window on sprite_y.
- PENGUIN_X, 576: penguin x that counts as "in this lane".
- RESPAWN_DELAY, 700: frames spent in WAIT before a new fall (≥1).
- CRUSH_HOLD, 30: frames spent in CRUSHED (≥1).
- COLOR_FILL, 24'h680100: RGB of palette index 2; index 1 is black.

Ports:
- i_clk, in, 1: pixel clock.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_x, in, 16: current pixel x.
- i_y, in, 16: current pixel y.
- i_v_sync, in, 1: vertical sync, asynchronous to nothing but treated as a level to be edge-detected.
- i_penguin_x, in, 16: penguin left x.
- i_penguin_jump, in, 1: penguin airborne.
- i_is_finished, in, 1: game finished; freezes the block.
- i_is_dead, in, 1: penguin dead; freezes the block.
- o_red, out, 8: pixel red, registered.
- o_green, out, 8: pixel green, registered.
- o_blue, out, 8: pixel blue, registered.
- o_sprite_hit, out, 1: opaque obstacle pixel at (i_x, i_y), registered.
- o_crushed, out, 1: one-cycle pulse when the penguin is crushed.
- o_active, out, 1: state == FALL.
- o_sprite_y, out, 16: current sprite_y.

## Operation

- **Frame tick.** i_v_sync passes through a 2-FF synchroniser. Its rising edge gives `tick`, a one-i_clk pulse.
- **Freeze.** While i_is_finished or i_is_dead is high, ticks are ignored and all state, counters and sprite_y hold. The pixel path keeps running.
- **Reset values.** state = WAIT, delay = 0, sprite_y = 0, hold = 0. All outputs are 0.
- **FSM.** All transitions happen on an unfrozen tick.
  - **WAIT.**
    - If delay == RESPAWN_DELAY−1: go to FALL, sprite_y = 0, delay = 0.
    - Otherwise delay++.
  - **FALL.** Priority order:
    - Crush: if !i_penguin_jump && CRUSH_Y_LO < sprite_y < CRUSH_Y_HI && i_penguin_x == PENGUIN_X: go to CRUSHED, hold = 0, pulse o_crushed.
    - Bottom: else if sprite_y == Y_BOTTOM: go to WAIT, delay = 0.
    - Otherwise sprite_y++.
  - **CRUSHED.**
    - If hold == CRUSH_HOLD−1: go to WAIT, delay = 0.
    - Otherwise hold++.
- **Geometry** (combinational from sprite_y):
  - s = 0 if sprite_y < SCALE2_Y; 1 if sprite_y < SCALE4_Y; 2 otherwise.
  - size = 32 << s.
  - sprite_x = X_CENTER − (16 << s) + ((X_DRIFT × sprite_y) >>> 6).
  - sprite_x is 16-bit two's complement; it wraps with no clamping.
- **In-box test.**
  - dx = i_x − sprite_x and dy = i_y − sprite_y, both 16-bit unsigned.
  - in_box = dx < size && dy < size. A negative difference wraps large, so it falls outside the box.
- **ROM lookup.** idx = ROM[dy >> s][dx >> s], taking 5 bits of each. The 32×32 ROM is 2 bits per pixel:
  - index 2 is the rim;
  - index 1 is the interior;
  - index 0 is transparent;
  - row 10 is cols 11–20 = 2;
  - row 16 is cols 5–6 = 2, cols 7–24 = 1, cols 25–26 = 2;
  - rows 0–9 and 21–31 are all 0.
- **Draw and hit.**
  - draw = in_box && state == FALL.
  - Colour = palette[idx] when draw, else 24'h000000.
  - o_sprite_hit = draw && idx != 0 && sprite_y ≥ HIT_Y_MIN.
  - Nothing is drawn in WAIT or CRUSHED.

## Timing

- i_v_sync rise to `tick`: 2–3 i_clk cycles.
- State, sprite_y and o_crushed update on the i_clk edge that samples `tick`. o_crushed is high for exactly that one cycle.
- Pixel path has 1 cycle of latency: outputs at edge n reflect i_x/i_y/state at edge n−1.
- Reset asserted mid-fall forces reset values immediately, independent of i_clk. The first tick after release counts toward the initial RESPAWN_DELAY.
- Crush condition true on the same tick as sprite_y == Y_BOTTOM: crush wins. This is only reachable with a misconfigured window.
- Freeze asserted on the same cycle as `tick`: the tick is dropped.

## Test plan

1. **Respawn timing.** RESPAWN_DELAY = 3: reset, then 3 ticks → o_active rises on the 3rd tick, o_sprite_y = 0. 593 further ticks → back to WAIT, o_active = 0.
2. **Scaling at centre.** X_DRIFT = 0, sprite_y = 299 → box x 624–655. sprite_y = 300 → box x 608–671. sprite_y = 450 → box x 576–703, and pixel (640, 450 + 64) returns ROM[16][16] = 1, i.e. black, with o_sprite_hit = 1.
3. **Drift lane.** X_DRIFT = 16, sprite_y = 200 → sprite_x = 640 − 16 + 50 = 674. Pixel (674 + 11, 210) → rim colour 680100, hit = 1. Pixel (673, 210) → 0, no hit.
4. **Crush.** sprite_y = 545, i_penguin_x = 576, jump = 0, tick → o_crushed pulses for exactly 1 cycle; state CRUSHED; no draw for CRUSH_HOLD ticks; then WAIT. Repeat with jump = 1 → no crush and sprite_y = 546.
5. **Freeze.** i_is_dead = 1 for 10 ticks at sprite_y = 100 → o_sprite_y stays 100 and the pixel output is still drawn. Deassert, then 1 tick → 101.
6. **Hit threshold and reset.** sprite_y = 143 → opaque pixels give colour but o_sprite_hit = 0. At 144 → o_sprite_hit = 1. Assert i_rst asynchronously → all outputs 0 before the next i_clk edge.

Source files
------------

// File: rtl/sprite_obstacle_lane.sv
// One-lane hole obstacle: frame-ticked WAIT/FALL/CRUSHED sequencer with depth-scaled,
// slope-drifted sprite geometry and a registered pixel/hit output.
module sprite_obstacle_lane #(
  parameter int          X_CENTER      = 640,
  parameter int          X_DRIFT       = 0,
  parameter int          Y_BOTTOM      = 592,
  parameter int          SCALE2_Y      = 300,
  parameter int          SCALE4_Y      = 450,
  parameter int          HIT_Y_MIN     = 144,
  parameter int          CRUSH_Y_LO    = 540,
  parameter int          CRUSH_Y_HI    = 550,
  parameter int          PENGUIN_X     = 576,
  parameter int          RESPAWN_DELAY = 700,
  parameter int          CRUSH_HOLD    = 30,
  parameter logic [23:0] COLOR_FILL    = 24'h680100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_v_sync,
  input  logic [15:0] i_penguin_x,
  input  logic        i_penguin_jump,
  input  logic        i_is_finished,
  input  logic        i_is_dead,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_sprite_hit,
  output logic        o_crushed,
  output logic        o_active,
  output logic [15:0] o_sprite_y
);

  localparam logic [15:0] Y_BOT      = 16'(Y_BOTTOM);
  localparam logic [15:0] SC2        = 16'(SCALE2_Y);
  localparam logic [15:0] SC4        = 16'(SCALE4_Y);
  localparam logic [15:0] HIT_MIN    = 16'(HIT_Y_MIN);
  localparam logic [15:0] CR_LO      = 16'(CRUSH_Y_LO);
  localparam logic [15:0] CR_HI      = 16'(CRUSH_Y_HI);
  localparam logic [15:0] PEN_X      = 16'(PENGUIN_X);
  localparam logic [15:0] DELAY_LAST = 16'(RESPAWN_DELAY - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CRUSH_HOLD - 1);
  localparam int signed   XC         = X_CENTER;
  localparam int signed   DRIFT_K    = X_DRIFT;

  typedef enum logic [1:0] {ST_WAIT, ST_FALL, ST_CRUSHED} state_t;

  state_t      state_q, state_d;
  logic [15:0] delay_q, delay_d, hold_q, hold_d, sy_q, sy_d;
  logic        crushed_q, crushed_d;
  logic [2:0]  vs_q;
  logic        tick;
  logic [23:0] rgb_q, rgb_d;
  logic        hit_q, hit_d;

  // vs_q[1:0] is the synchroniser, vs_q[2] the edge-detect delay
  assign tick = vs_q[1] & ~vs_q[2] & ~i_is_finished & ~i_is_dead;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vs_q      <= '0;
      state_q   <= ST_WAIT;
      delay_q   <= '0;
      hold_q    <= '0;
      sy_q      <= '0;
      crushed_q <= 1'b0;
      rgb_q     <= '0;
      hit_q     <= 1'b0;
    end else begin
      vs_q      <= {vs_q[1:0], i_v_sync};
      state_q   <= state_d;
      delay_q   <= delay_d;
      hold_q    <= hold_d;
      sy_q      <= sy_d;
      crushed_q <= crushed_d;
      rgb_q     <= rgb_d;
      hit_q     <= hit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    hold_d    = hold_q;
    sy_d      = sy_q;
    crushed_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_WAIT: begin
          if (delay_q == DELAY_LAST) begin
            state_d = ST_FALL;
            sy_d    = '0;
            delay_d = '0;
          end else begin
            delay_d = delay_q + 16'd1;
          end
        end
        ST_FALL: begin
          if (!i_penguin_jump && sy_q > CR_LO && sy_q < CR_HI && i_penguin_x == PEN_X) begin
            state_d   = ST_CRUSHED;
            hold_d    = '0;
            crushed_d = 1'b1;
          end else if (sy_q == Y_BOT) begin
            state_d = ST_WAIT;
            delay_d = '0;
          end else begin
            sy_d = sy_q + 16'd1;
          end
        end
        ST_CRUSHED: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_WAIT;
            delay_d = '0;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // Hole outline, symmetric about col 15.5: per row, rim from lo, interior from in_lo
  function automatic logic [1:0] rom_idx(input logic [4:0] row, input logic [4:0] col);
    logic [4:0] lo, in_lo, mc;
    logic [1:0] v;
    lo    = 5'd31;
    in_lo = 5'd31;
    v     = 2'd0;
    case (row)
      5'd10, 5'd20:                      begin lo = 5'd11; in_lo = 5'd21; end
      5'd11, 5'd19:                      begin lo = 5'd8;  in_lo = 5'd10; end
      5'd12, 5'd18:                      begin lo = 5'd6;  in_lo = 5'd8;  end
      5'd13, 5'd14, 5'd15, 5'd16, 5'd17: begin lo = 5'd5;  in_lo = 5'd7;  end
      default: ;
    endcase
    mc = (col > 5'd15) ? 5'd31 - col : col;
    if (mc >= in_lo)   v = 2'd1;
    else if (mc >= lo) v = 2'd2;
    return v;
  endfunction

  logic [1:0]         s, idx;
  logic [15:0]        size, half, sprite_x, dx, dy;
  logic [4:0]         row, col;
  logic signed [31:0] drift_prod;
  logic               in_box, draw;

  always_comb begin
    if (sy_q < SC2)      s = 2'd0;
    else if (sy_q < SC4) s = 2'd1;
    else                 s = 2'd2;
    size       = 16'd32 << s;
    half       = 16'd16 << s;
    drift_prod = DRIFT_K * $signed({16'd0, sy_q});
    sprite_x   = 16'(XC - int'(half) + (drift_prod >>> 6));
    dx         = i_x - sprite_x;
    dy         = i_y - sy_q;
    in_box     = (dx < size) && (dy < size);
    unique case (s)
      2'd0:    begin col = dx[4:0]; row = dy[4:0]; end
      2'd1:    begin col = dx[5:1]; row = dy[5:1]; end
      default: begin col = dx[6:2]; row = dy[6:2]; end
    endcase
    idx   = rom_idx(row, col);
    draw  = in_box && (state_q == ST_FALL);
    rgb_d = (draw && idx == 2'd2) ? COLOR_FILL : 24'h000000;
    hit_d = draw && (idx != 2'd0) && (sy_q >= HIT_MIN);
  end

  assign o_red        = rgb_q[23:16];
  assign o_green      = rgb_q[15:8];
  assign o_blue       = rgb_q[7:0];
  assign o_sprite_hit = hit_q;
  assign o_crushed    = crushed_q;
  assign o_active     = (state_q == ST_FALL);
  assign o_sprite_y   = sy_q;

endmodule

// File: tb/tb_sprite_obstacle_lane.sv
// Bench for sprite_obstacle_lane: a centre lane and a drifting lane share all stimulus.
module tb_sprite_obstacle_lane;

  logic        clk = 1'b0;
  logic        rst, vs, jump, fin, dead;
  logic [15:0] x, y, pen_x;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        hit0, hit1, cr0, cr1, act0, act1;
  logic [15:0] sy0, sy1;

  always #5 clk = ~clk;

  sprite_obstacle_lane #(.X_DRIFT(0), .RESPAWN_DELAY(3), .CRUSH_HOLD(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_v_sync(vs),
    .i_penguin_x(pen_x), .i_penguin_jump(jump), .i_is_finished(fin), .i_is_dead(dead),
    .o_red(r0), .o_green(g0), .o_blue(b0), .o_sprite_hit(hit0),
    .o_crushed(cr0), .o_active(act0), .o_sprite_y(sy0));

  sprite_obstacle_lane #(.X_DRIFT(16), .RESPAWN_DELAY(3), .CRUSH_HOLD(4)) u_drift (
    .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_v_sync(vs),
    .i_penguin_x(pen_x), .i_penguin_jump(jump), .i_is_finished(fin), .i_is_dead(dead),
    .o_red(r1), .o_green(g1), .o_blue(b1), .o_sprite_hit(hit1),
    .o_crushed(cr1), .o_active(act1), .o_sprite_y(sy1));

  typedef struct packed {logic [23:0] rgb; logic hit;} px_t;

  px_t sb[$];
  px_t e, got;
  int  tests = 0;
  int  fails = 0;
  int  exp_y = 0;

  // One frame: v_sync low for two cycles then high; returns on the negedge after the update edge
  task automatic tick();
    @(negedge clk) vs = 1'b0;
    @(negedge clk);
    @(negedge clk) vs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic step_to(input int target);
    while (exp_y < target) begin
      tick();
      exp_y++;
    end
  endtask

  task automatic drive_px(input logic [15:0] px, input logic [15:0] py, input px_t exp_v);
    @(negedge clk);
    x = px;
    y = py;
    sb.push_back(exp_v);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; vs = 1'b0; jump = 1'b0; fin = 1'b0; dead = 1'b0;
    pen_x = '0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({r0, g0, b0, hit0, cr0, act0, sy0} !== 43'd0) begin
      fails++;
      $display("FAIL reset_lane0 got=%h exp=0", {r0, g0, b0, hit0, cr0, act0, sy0});
    end
    tests++;
    if ({r1, g1, b1, hit1, cr1, act1, sy1} !== 43'd0) begin
      fails++;
      $display("FAIL reset_lane1 got=%h exp=0", {r1, g1, b1, hit1, cr1, act1, sy1});
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_respawn();
    tick();
    tick();
    tests++;
    if (act0 !== 1'b0) begin fails++; $display("FAIL respawn_early got=%b exp=0", act0); end
    tick();
    exp_y = 0;
    tests++;
    if ({act0, sy0} !== {1'b1, 16'd0}) begin
      fails++; $display("FAIL respawn_start got act=%b y=%0d exp act=1 y=0", act0, sy0);
    end
  endtask

  task automatic test_freeze();
    step_to(100);
    dead = 1'b1;
    repeat (10) tick();
    tests++;
    if ({act0, sy0} !== {1'b1, 16'd100}) begin
      fails++; $display("FAIL freeze_hold got act=%b y=%0d exp act=1 y=100", act0, sy0);
    end
    drive_px(16'd635, 16'd110, {24'h680100, 1'b0});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL freeze_draw got=%h exp=%h", got, e); end
    dead = 1'b0;
    tick();
    exp_y++;
    tests++;
    if (sy0 !== 16'(exp_y)) begin fails++; $display("FAIL freeze_release got=%0d exp=%0d", sy0, exp_y); end
  endtask

  task automatic test_hit_threshold();
    step_to(143);
    drive_px(16'd635, 16'd153, {24'h680100, 1'b0});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL thr143_rim got=%h exp=%h", got, e); end
    drive_px(16'd640, 16'd159, {24'h000000, 1'b0});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL thr143_inner got=%h exp=%h", got, e); end
    step_to(144);
    drive_px(16'd635, 16'd154, {24'h680100, 1'b1});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL thr144_rim got=%h exp=%h", got, e); end
    drive_px(16'd640, 16'd160, {24'h000000, 1'b1});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL thr144_inner got=%h exp=%h", got, e); end
  endtask

  task automatic test_drift();
    step_to(200);
    tests++;
    if (sy1 !== 16'd200) begin fails++; $display("FAIL drift_y got=%0d exp=200", sy1); end
    drive_px(16'd685, 16'd210, {24'h680100, 1'b1});
    got = {r1, g1, b1, hit1}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL drift_rim got=%h exp=%h", got, e); end
    drive_px(16'd673, 16'd210, {24'h000000, 1'b0});
    got = {r1, g1, b1, hit1}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL drift_left_out got=%h exp=%h", got, e); end
    drive_px(16'd635, 16'd210, {24'h680100, 1'b1});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL drift_centre_ref got=%h exp=%h", got, e); end
  endtask

  task automatic test_scaling();
    step_to(299);
    drive_px(16'd635, 16'd309, {24'h680100, 1'b1});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL scale1_rim got=%h exp=%h", got, e); end
    step_to(300);
    drive_px(16'd630, 16'd320, {24'h680100, 1'b1});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL scale2_rim got=%h exp=%h", got, e); end
    drive_px(16'd629, 16'd320, {24'h000000, 1'b0});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL scale2_edge got=%h exp=%h", got, e); end
    step_to(450);
    drive_px(16'd640, 16'd514, {24'h000000, 1'b1});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL scale4_inner got=%h exp=%h", got, e); end
    drive_px(16'd620, 16'd490, {24'h680100, 1'b1});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL scale4_rim got=%h exp=%h", got, e); end
    drive_px(16'd619, 16'd490, {24'h000000, 1'b0});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL scale4_edge got=%h exp=%h", got, e); end
  endtask

  task automatic test_bottom();
    step_to(592);
    tests++;
    if ({act0, sy0} !== {1'b1, 16'd592}) begin
      fails++; $display("FAIL bottom_reach got act=%b y=%0d exp act=1 y=592", act0, sy0);
    end
    tick();
    tests++;
    if ({act0, sy0} !== {1'b0, 16'd592}) begin
      fails++; $display("FAIL bottom_wait got act=%b y=%0d exp act=0 y=592", act0, sy0);
    end
    drive_px(16'd620, 16'd632, {24'h000000, 1'b0});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL wait_nodraw got=%h exp=%h", got, e); end
  endtask

  task automatic test_crush();
    repeat (3) tick();
    exp_y = 0;
    step_to(545);
    pen_x = 16'd576;
    jump  = 1'b0;
    tick();
    tests++;
    if ({cr0, act0, sy0} !== {1'b1, 1'b0, 16'd545}) begin
      fails++; $display("FAIL crush_pulse got cr=%b act=%b y=%0d exp cr=1 act=0 y=545", cr0, act0, sy0);
    end
    pen_x = 16'd0;
    @(negedge clk);
    tests++;
    if (cr0 !== 1'b0) begin fails++; $display("FAIL crush_width got=%b exp=0", cr0); end
    drive_px(16'd620, 16'd585, {24'h000000, 1'b0});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL crushed_nodraw got=%h exp=%h", got, e); end
    repeat (6) tick();
    tests++;
    if ({cr0, act0} !== 2'b00) begin fails++; $display("FAIL crush_hold got cr=%b act=%b exp 00", cr0, act0); end
    tick();
    exp_y = 0;
    tests++;
    if ({act0, sy0} !== {1'b1, 16'd0}) begin
      fails++; $display("FAIL crush_respawn got act=%b y=%0d exp act=1 y=0", act0, sy0);
    end
  endtask

  task automatic test_jump();
    step_to(540);
    pen_x = 16'd576;
    jump  = 1'b1;
    step_to(546);
    tests++;
    if ({cr0, act0, sy0} !== {1'b0, 1'b1, 16'd546}) begin
      fails++; $display("FAIL jump_nocrush got cr=%b act=%b y=%0d exp cr=0 act=1 y=546", cr0, act0, sy0);
    end
  endtask

  task automatic test_async_reset();
    drive_px(16'd624, 16'd586, {24'h680100, 1'b1});
    got = {r0, g0, b0, hit0}; e = sb.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL prereset_rim got=%h exp=%h", got, e); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({r0, g0, b0, hit0, cr0, act0, sy0} !== 43'd0) begin
      fails++; $display("FAIL async_reset got=%h exp=0", {r0, g0, b0, hit0, cr0, act0, sy0});
    end
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_respawn();
    test_freeze();
    test_hit_threshold();
    test_drift();
    test_scaling();
    test_bottom();
    test_crush();
    test_jump();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
